// File: rtl/grdes_pkg.sv
// grdes_pkg: shared widths and FSM state encoding for the GrDes sweep controller
package grdes_pkg;
  localparam int Z_W = 32;
  localparam int COORD_W = 8;
  localparam int IDX_W = 8;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, RELEASE, WAIT_CLR, DONE} state_t;
endpackage

// File: rtl/grdes_best_tracker.sv
// grdes_best_tracker: keeps the lowest signed z_min of the sweep with its coordinates and index
module grdes_best_tracker
  import grdes_pkg::*;
#(
  parameter int ZW = 32
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      upd,
  input  logic signed [ZW-1:0]      z,
  input  logic [IDX_W-1:0]          idx,
  input  logic signed [COORD_W-1:0] fa,
  input  logic signed [COORD_W-1:0] fb,
  input  logic signed [COORD_W-1:0] fc,
  input  logic signed [COORD_W-1:0] fd,
  output logic signed [ZW-1:0]      best_z,
  output logic signed [COORD_W-1:0] best_a,
  output logic signed [COORD_W-1:0] best_b,
  output logic signed [COORD_W-1:0] best_c,
  output logic signed [COORD_W-1:0] best_d,
  output logic [IDX_W-1:0]          best_idx,
  output logic                      best_valid
);
  logic take;
  // strict less-than so that ties keep the earlier point
  assign take = upd && (!best_valid || z < best_z);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || clr) begin
      best_z <= '0;
      {best_a, best_b, best_c, best_d} <= '0;
      best_idx <= '0;
      best_valid <= 1'b0;
    end else if (take) begin
      best_z <= z;
      {best_a, best_b, best_c, best_d} <= {fa, fb, fc, fd};
      best_idx <= idx;
      best_valid <= 1'b1;
    end
endmodule

// File: rtl/grdes_sweep_ctrl.sv
// grdes_sweep_ctrl: sweeps start points through one GrDes core, reporting each result and the best
module grdes_sweep_ctrl
  import grdes_pkg::*;
#(
  parameter int                         NUM_POINTS     = 49,
  parameter logic signed [COORD_W-1:0]  INCREMENT      = 8'sh01,
  parameter int                         TIMEOUT_CYCLES = 4096,
  parameter int                         Z_W            = 32
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sweep_start,
  input  logic signed [COORD_W-1:0] a_base,
  input  logic signed [COORD_W-1:0] b_base,
  input  logic signed [COORD_W-1:0] c_base,
  input  logic signed [COORD_W-1:0] d_base,
  output logic                      sweep_busy,
  output logic                      sweep_done,
  output logic                      core_rst_n,
  output logic                      core_start_op,
  output logic signed [COORD_W-1:0] core_a,
  output logic signed [COORD_W-1:0] core_b,
  output logic signed [COORD_W-1:0] core_c,
  output logic signed [COORD_W-1:0] core_d,
  input  logic                      core_done_op,
  input  logic signed [Z_W-1:0]     core_z_min,
  input  logic signed [COORD_W-1:0] core_fa,
  input  logic signed [COORD_W-1:0] core_fb,
  input  logic signed [COORD_W-1:0] core_fc,
  input  logic signed [COORD_W-1:0] core_fd,
  output logic                      pt_valid,
  output logic [IDX_W-1:0]          pt_idx,
  output logic signed [Z_W-1:0]     pt_z,
  output logic                      pt_timeout,
  output logic signed [Z_W-1:0]     best_z,
  output logic signed [COORD_W-1:0] best_a,
  output logic signed [COORD_W-1:0] best_b,
  output logic signed [COORD_W-1:0] best_c,
  output logic signed [COORD_W-1:0] best_d,
  output logic [IDX_W-1:0]          best_idx,
  output logic                      best_valid
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [WD_W-1:0] wd;
  logic to_flag, wd_exp, last, step;
  assign wd_exp = wd == WD_W'(TIMEOUT_CYCLES - 1);
  assign last = idx == IDX_W'(NUM_POINTS - 1);
  assign step = state == WAIT_CLR && !core_done_op && !last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = sweep_start ? LOAD : IDLE;
      LOAD:     state_nx = RUN;
      RUN:      state_nx = (core_done_op || wd_exp) ? CAPTURE : RUN;
      CAPTURE:  state_nx = RELEASE;
      RELEASE:  state_nx = WAIT_CLR;
      WAIT_CLR: state_nx = core_done_op ? WAIT_CLR : last ? DONE : RUN;
      default:  state_nx = IDLE;
    endcase
  end
  // every output is a registered decode of the current state, one cycle behind it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {sweep_busy, sweep_done, core_start_op, pt_valid, pt_timeout, to_flag} <= '0;
      core_rst_n <= 1'b0;
      {core_a, core_b, core_c, core_d} <= '0;
      pt_idx <= '0;
      pt_z <= '0;
      idx <= '0;
      wd <= '0;
    end else begin
      sweep_busy <= state inside {LOAD, RUN, CAPTURE, RELEASE, WAIT_CLR};
      sweep_done <= state == DONE;
      core_rst_n <= state != RELEASE;
      core_start_op <= state == RUN;
      pt_valid <= state == CAPTURE;
      pt_timeout <= state == CAPTURE && to_flag;
      wd <= state == RUN ? wd + 1'b1 : '0;
      if (state == RUN) to_flag <= !core_done_op;
      if (state == CAPTURE) begin
        pt_idx <= idx;
        pt_z <= core_z_min;
      end
      if (state == IDLE && sweep_start) {core_a, core_b, core_c, core_d} <= {a_base, b_base, c_base, d_base};
      if (state == LOAD) idx <= '0;
      if (step) begin
        idx <= idx + 1'b1;
        core_a <= core_a + INCREMENT;
        core_b <= core_b + INCREMENT;
        core_c <= core_c + INCREMENT;
        core_d <= core_d + INCREMENT;
      end
    end
  grdes_best_tracker #(.ZW(Z_W)) u_best (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (state == LOAD),
    .upd        (state == CAPTURE && !to_flag),
    .z          (core_z_min),
    .idx        (idx),
    .fa         (core_fa),
    .fb         (core_fb),
    .fc         (core_fc),
    .fd         (core_fd),
    .best_z     (best_z),
    .best_a     (best_a),
    .best_b     (best_b),
    .best_c     (best_c),
    .best_d     (best_d),
    .best_idx   (best_idx),
    .best_valid (best_valid)
  );
endmodule

// File: tb/tb_grdes_sweep_ctrl.sv
// tb_grdes_sweep_ctrl: directed sweep vectors against a behavioural GrDes core model
module tb_grdes_sweep_ctrl;
  localparam int NP = 4;
  localparam int TO = 16;
  logic clk = 0, rst_n = 0, sweep_start = 0;
  logic [7:0] a_base = 0, b_base = 0, c_base = 0, d_base = 0;
  logic sweep_busy, sweep_done, core_rst_n, core_start_op, core_done_op;
  logic [7:0] core_a, core_b, core_c, core_d;
  logic [31:0] core_z_min, pt_z, best_z;
  logic [7:0] pt_idx, best_idx, best_a, best_b, best_c, best_d;
  logic pt_valid, pt_timeout, best_valid;
  int checks = 0, errors = 0;

  logic [31:0] ztab [4];
  logic [3:0] hang = 0;
  int lat = 0, cnt = 0, midx = 0;

  grdes_sweep_ctrl #(.NUM_POINTS(NP), .INCREMENT(8'sh01), .TIMEOUT_CYCLES(TO), .Z_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .sweep_start(sweep_start),
    .a_base(a_base), .b_base(b_base), .c_base(c_base), .d_base(d_base),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .core_rst_n(core_rst_n), .core_start_op(core_start_op),
    .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d),
    .core_done_op(core_done_op), .core_z_min(core_z_min),
    .core_fa(core_a), .core_fb(core_b), .core_fc(core_c), .core_fd(core_d),
    .pt_valid(pt_valid), .pt_idx(pt_idx), .pt_z(pt_z), .pt_timeout(pt_timeout),
    .best_z(best_z), .best_a(best_a), .best_b(best_b), .best_c(best_c), .best_d(best_d),
    .best_idx(best_idx), .best_valid(best_valid)
  );

  always #5 clk = ~clk;

  // GrDes model: done rises lat+1 cycles after start is seen, never on a hung point; its point
  // index counts core resets since the accepted sweep_start
  assign core_z_min = ztab[midx[1:0]];
  always @(posedge clk) begin
    if (sweep_start && !sweep_busy) midx <= 0;
    else if (!core_rst_n) midx <= midx + 1;
    if (!core_rst_n) begin
      cnt <= 0;
      core_done_op <= 1'b0;
    end else if (core_start_op && !core_done_op && !hang[midx[1:0]]) begin
      if (cnt == lat) core_done_op <= 1'b1;
      else cnt <= cnt + 1;
    end
  end

  typedef struct {
    logic [7:0] a, b, c, d;
    int lat;
    logic [3:0] hang;
    logic [3:0][31:0] z;
    logic poke;
    logic [31:0] eb_z;
    logic [7:0] eb_idx, eb_a, eb_d;
    logic eb_valid;
  } vec_t;
  vec_t vecs [5];

  function automatic vec_t mk(logic [7:0] a, b, c, d, int l, logic [3:0] h,
                              logic [31:0] z0, z1, z2, z3, logic poke,
                              logic [31:0] ez, logic [7:0] ei, ea, ed, logic ev);
    vec_t r;
    r.a = a; r.b = b; r.c = c; r.d = d;
    r.lat = l; r.hang = h; r.z = {z3, z2, z1, z0}; r.poke = poke;
    r.eb_z = ez; r.eb_idx = ei; r.eb_a = ea; r.eb_d = ed; r.eb_valid = ev;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic reset_checks();
    chk("rst_core_rst_n", 64'(core_rst_n), 0);
    chk("rst_flags", 64'({sweep_busy, sweep_done, core_start_op, pt_valid, pt_timeout, best_valid}), 0);
    chk("rst_coords", {core_a, core_b, core_c, core_d, best_a, best_b, best_c, best_d}, 0);
    chk("rst_z", {pt_z, best_z}, 0);
    chk("rst_idx", 64'({pt_idx, best_idx}), 0);
  endtask

  task automatic run_sweep(input vec_t v);
    int n = 0, cyc = 0, cyc_st = 0, low = 0, nd = 0;
    logic prev_st = 0;
    logic [7:0] ea;
    {a_base, b_base, c_base, d_base} = {v.a, v.b, v.c, v.d};
    lat = v.lat;
    hang = v.hang;
    for (int i = 0; i < 4; i++) ztab[i] = v.z[i];
    @(negedge clk) sweep_start = 1;
    @(negedge clk) sweep_start = 0;
    while (!sweep_done && cyc < 2000) begin
      sweep_start = v.poke && cyc == 10;
      if (core_start_op && !prev_st) begin
        cyc_st = cyc;
        ea = v.a + 8'(n);
        chk("start_waits_done_low", 64'(core_done_op), 0);
        chk("start_core_a", 64'(core_a), 64'(ea));
        if (n == 0) chk("start_latency", cyc, 2);
      end
      if (!core_rst_n) low++;
      else if (low > 0) begin
        chk("core_rst_pulse", low, 1);
        low = 0;
      end
      if (pt_valid) begin
        chk("pt_idx", 64'(pt_idx), 64'(n));
        chk("pt_timeout", 64'(pt_timeout), 64'(v.hang[n[1:0]]));
        if (!v.hang[n[1:0]]) chk("pt_z", 64'(pt_z), 64'(v.z[n[1:0]]));
        chk("pt_latency", cyc - cyc_st, v.hang[n[1:0]] ? TO : v.lat + 3);
        n++;
      end
      prev_st = core_start_op;
      @(negedge clk);
      cyc++;
    end
    sweep_start = 0;
    chk("sweep_done_seen", 64'(sweep_done), 1);
    chk("points", n, NP);
    chk("busy_at_done", 64'(sweep_busy), 0);
    chk("best_valid", 64'(best_valid), 64'(v.eb_valid));
    chk("best_z", 64'(best_z), 64'(v.eb_z));
    chk("best_idx", 64'(best_idx), 64'(v.eb_idx));
    chk("best_a_d", 64'({best_a, best_d}), 64'({v.eb_a, v.eb_d}));
    repeat (20) begin
      @(negedge clk);
      nd += int'(sweep_done);
    end
    chk("single_sweep_done", nd, 0);
    chk("best_hold", 64'(best_z), 64'(v.eb_z));
  endtask

  // abort a sweep with rst_n while point 2 is running
  task automatic mid_reset();
    int n = 0, cyc = 0, nd = 0;
    lat = 10;
    hang = 0;
    for (int i = 0; i < 4; i++) ztab[i] = 32'(i + 1);
    a_base = 8'h11;
    @(negedge clk) sweep_start = 1;
    @(negedge clk) sweep_start = 0;
    while (cyc < 500 && !(n == 2 && core_start_op)) begin
      n += int'(pt_valid);
      @(negedge clk);
      cyc++;
    end
    chk("reach_point2_run", {32'(n), 31'(0), core_start_op}, {32'd2, 32'd1});
    rst_n = 0;
    #1;
    reset_checks();
    @(negedge clk) rst_n = 1;
    repeat (40) begin
      @(negedge clk);
      nd += int'(sweep_done);
    end
    chk("no_done_after_abort", nd, 0);
    chk("idle_after_abort", 64'({sweep_busy, core_rst_n}), 64'(2'b01));
  endtask

  initial begin
    vecs[0] = mk(8'h00, 8'h00, 8'h00, 8'h00, 3, 4'b0000, 100, 40, 40, 70, 0, 40, 1, 8'h01, 8'h01, 1);
    vecs[1] = mk(8'h7E, 8'h01, 8'hFE, 8'h10, 0, 4'b0010, 50, 10, 60, 20, 0, 20, 3, 8'h81, 8'h13, 1);
    vecs[2] = mk(8'h05, 8'h00, 8'h00, 8'hF0, 2, 4'b0000, 100, 3, 32'hFFFF_FF00, 32'hFFFF_FF00, 1,
                 32'hFFFF_FF00, 2, 8'h07, 8'hF2, 1);
    vecs[3] = mk(8'h40, 8'h00, 8'h00, 8'h80, 13, 4'b0000, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 0, 7, 0,
                 32'hFFFF_FFFB, 0, 8'h40, 8'h80, 1);
    vecs[4] = mk(8'h20, 8'h00, 8'h00, 8'h00, 1, 4'b1111, 1, 2, 3, 4, 0, 0, 0, 8'h00, 8'h00, 0);
    for (int i = 0; i < 4; i++) ztab[i] = 0;
    repeat (3) @(negedge clk);
    reset_checks();
    rst_n = 1;
    @(negedge clk);
    chk("idle_core_rst_n", 64'(core_rst_n), 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) mid_reset();
      run_sweep(vecs[i]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
